button_bank_fsm: RTL and testbench
==================================

Name: button_bank_fsm

Overview:
- Parametrised, multi-channel successor to the single-channel toggle button FSM.
- Each of CHANNELS raw button inputs gets a debouncer, a press-edge detector, a long-press timer and a per-channel output mode (toggle, momentary, latch, disabled).
- Sits between board push-buttons and control logic; provides both level outputs (stateful_button) and one-cycle event strobes.

Parameters:
- CHANNELS, 4, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 3, consecutive samples that must differ from the debounced level before it flips (>=1).
- LONG_PRESS_CYCLES, 8, cycles after press_pulse at which long_press fires (>=1).
- CNT_W, 8, width of the internal debounce and hold counters; must hold max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- button  input  CHANNELS  raw button levels, bit i = channel i; sampled on every posedge.
- mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 toggle, 01 momentary, 10 latch, 11 disabled.
- clear  input  1  synchronous clear of every stateful_button bit.
- stateful_button  output  CHANNELS  registered per-channel level output.
- press_pulse  output  CHANNELS  one-cycle strobe on each debounced press.
- long_press  output  CHANNELS  one-cycle strobe when a press has been held LONG_PRESS_CYCLES.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset (rst=1 at a posedge): all outputs, debounced levels db[i], debounce counters and hold counters go to 0. Priority is rst > clear > press/mode logic.
- Reset mid-debounce or mid-hold discards the partial count; nothing is emitted.
- Debounce, per channel:
  - If button[i] != db[i] at a posedge, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES, db[i] flips on that same edge and the counter clears.
  - Latency: the first differing sample at edge k gives db=1 after edge k+DEBOUNCE_CYCLES-1.
  - Any matching sample restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Per-channel state machine (states are encoded by db and the hold counter):
  - IDLE (db=0) -> PRESSED on db rising. PRESSED -> HELD when hold count = LONG_PRESS_CYCLES.
  - PRESSED or HELD -> IDLE on db falling.
- press_pulse[i]: asserted for exactly the one cycle following the edge where db[i] rises. It fires in every mode except disabled. It is never asserted on release.
- long_press[i]:
  - The hold counter loads 0 at the press edge, then increments each cycle db[i]=1, saturating.
  - long_press[i] is high for one cycle when the counter reaches LONG_PRESS_CYCLES, i.e. LONG_PRESS_CYCLES cycles after press_pulse.
  - It fires at most once per press. Release before the threshold gives no strobe, and the counter clears on release.
- stateful_button[i], updated on the press edge:
  - 00 toggle: inverts on each press.
  - 01 momentary: equals db[i], registered on the same edge as db.
  - 10 latch: set to 1 on a press; cleared only by clear or rst.
  - 11 disabled: forced to 0; press_pulse and long_press are suppressed, but debounce keeps running.
- clear: at a posedge with clear=1, every stateful_button bit goes to 0.
  - clear wins over a coincident press. press_pulse still fires for that press.
  - In momentary mode the output reasserts on the next edge if db is still 1.
- Mode change takes effect at the next posedge:
  - Entering momentary makes the output follow db on that edge.
  - Leaving momentary for toggle or latch retains the current value.
  - Entering disabled forces 0.
- Channels are fully independent. Simultaneous presses on several channels each produce their own strobes in the same cycle.

Test Plan:
- Defaults throughout: CHANNELS=4, DEBOUNCE_CYCLES=3, LONG_PRESS_CYCLES=8, mode=all toggle.
- Reset: hold rst=1 for 2 cycles with button=4'hF -> all outputs 0. Release rst with buttons held -> press_pulse=4'hF for one cycle 3 edges later, and stateful_button=4'hF.
- Glitch and toggle: ch0 high 2 cycles then low -> no pulse, output stays 0. Two clean presses (6 high / 6 low) -> stateful_button[0] goes 0->1->0 with exactly 2 press_pulse strobes, each 3 cycles after the rising edge.
- Long press: ch0 held 20 cycles -> long_press[0] high for exactly one cycle, 8 cycles after press_pulse[0], and never again in that press. A 5-cycle hold -> no long_press.
- Modes: mode=8'b11_10_01_00, pressing all channels for 6 cycles then releasing:
  - ch1 follows db with 3-cycle lag on both edges.
  - ch2 stays 1 after release until clear=1, then 0.
  - ch3 output, press_pulse and long_press stay 0.
- Simultaneous events: clear=1 on the press edge in toggle mode -> stateful_button[0]=0 and press_pulse[0]=1. rst asserted mid-debounce (after 2 samples) -> no pulse; after rst drops, a fresh 3-sample debounce is required.

Source files
------------

// File: rtl/button_bank_fsm.sv
// Multi-channel push-button front end: debounce, press/long-press strobes
// and a per-channel level output with toggle, momentary, latch or off modes.
module button_bank_fsm #(
    parameter int CHANNELS          = 4,
    parameter int DEBOUNCE_CYCLES   = 3,
    parameter int LONG_PRESS_CYCLES = 8,
    parameter int CNT_W             = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     button,
    input  logic [2*CHANNELS-1:0]   mode,
    input  logic                    clear,
    output logic [CHANNELS-1:0]     stateful_button,
    output logic [CHANNELS-1:0]     press_pulse,
    output logic [CHANNELS-1:0]     long_press
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_PRESSED = 2'b01;
    localparam logic [1:0] S_HELD    = 2'b10;

    localparam logic [1:0] M_TOGGLE = 2'b00;
    localparam logic [1:0] M_MOMENT = 2'b01;
    localparam logic [1:0] M_LATCH  = 2'b10;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CHANNELS-1:0] r_db;
    logic [CNT_W-1:0]    r_deb  [CHANNELS];
    logic [CNT_W-1:0]    r_hold [CHANNELS];

    logic [CHANNELS-1:0] w_db_nxt;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_off;
    logic [CHANNELS-1:0] w_st_nxt;
    logic [CHANNELS-1:0] w_pp_nxt;
    logic [CHANNELS-1:0] w_lp_nxt;
    logic [CNT_W-1:0]    w_deb_nxt  [CHANNELS];
    logic [CNT_W-1:0]    w_hold_nxt [CHANNELS];
    logic [1:0]          w_md       [CHANNELS];
    logic [1:0]          w_fsm_cur  [CHANNELS];
    logic [1:0]          w_fsm_nxt  [CHANNELS];

    // Channel state is implied by the debounced level and the hold count.
    function automatic logic [1:0] f_state(input logic db,
                                           input logic [CNT_W-1:0] hold);
        if (!db)
            return S_IDLE;
        return (hold == HOLD_MAX) ? S_HELD : S_PRESSED;
    endfunction

    always_comb begin
        w_db_nxt = r_db;
        w_rise   = '0;
        w_off    = '0;
        w_st_nxt = '0;
        w_pp_nxt = '0;
        w_lp_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_deb_nxt[i]  = '0;
            w_hold_nxt[i] = r_hold[i];
            w_md[i]       = mode[2*i +: 2];
            w_fsm_cur[i]  = f_state(r_db[i], r_hold[i]);

            if (button[i] != r_db[i]) begin
                if (r_deb[i] == DEB_LAST)
                    w_db_nxt[i] = ~r_db[i];
                else
                    w_deb_nxt[i] = r_deb[i] + ONE;
            end

            w_rise[i] = w_db_nxt[i] & ~r_db[i];

            if (!w_db_nxt[i] || w_rise[i])
                w_hold_nxt[i] = '0;
            else if (r_hold[i] != HOLD_MAX)
                w_hold_nxt[i] = r_hold[i] + ONE;

            w_fsm_nxt[i] = f_state(w_db_nxt[i], w_hold_nxt[i]);

            w_off[i]    = (w_md[i] == 2'b11);
            w_pp_nxt[i] = w_rise[i] & ~w_off[i];
            w_lp_nxt[i] = (w_fsm_nxt[i] == S_HELD) &&
                          (w_fsm_cur[i] != S_HELD) && !w_off[i];

            case (w_md[i])
                M_TOGGLE: w_st_nxt[i] = stateful_button[i] ^ w_rise[i];
                M_MOMENT: w_st_nxt[i] = w_db_nxt[i];
                M_LATCH:  w_st_nxt[i] = stateful_button[i] | w_rise[i];
                default:  w_st_nxt[i] = 1'b0;
            endcase

            // Clear beats a coincident press; the strobe is still emitted.
            if (clear)
                w_st_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db            <= '0;
            stateful_button <= '0;
            press_pulse     <= '0;
            long_press      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_deb[i]  <= '0;
                r_hold[i] <= '0;
            end
        end else begin
            r_db            <= w_db_nxt;
            stateful_button <= w_st_nxt;
            press_pulse     <= w_pp_nxt;
            long_press      <= w_lp_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                r_deb[i]  <= w_deb_nxt[i];
                r_hold[i] <= w_hold_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_button_bank_fsm.sv
// Directed bench for button_bank_fsm: reset, debounce, toggle, long press,
// modes, clear and reset collisions, with hand-computed expectations.
module tb_button_bank_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] button;
    logic [7:0] mode;
    logic       clear;
    logic [3:0] stateful_button;
    logic [3:0] press_pulse;
    logic [3:0] long_press;

    int errors = 0;
    int checks = 0;
    int pp_n [4];
    int lp_n [4];

    button_bank_fsm dut (
        .clk             (clk),
        .rst             (rst),
        .button          (button),
        .mode            (mode),
        .clear           (clear),
        .stateful_button (stateful_button),
        .press_pulse     (press_pulse),
        .long_press      (long_press)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            pp_n[i] += int'(press_pulse[i]);
            lp_n[i] += int'(long_press[i]);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++)
            tick();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 4; i++) begin
            pp_n[i] = 0;
            lp_n[i] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        button = 4'hF;
        mode   = 8'h00;
        clear  = 1'b0;
        clr_cnt();

        // reset with all buttons held
        run(2);
        chk("rst_st", stateful_button, 4'h0);
        chk("rst_pp", press_pulse, 4'h0);
        chk("rst_lp", long_press, 4'h0);

        rst = 1'b0;
        tick();
        chk("rel_pp1", press_pulse, 4'h0);
        tick();
        chk("rel_pp2", press_pulse, 4'h0);
        tick();
        chk("rel_pp3", press_pulse, 4'hF);
        chk("rel_st3", stateful_button, 4'hF);
        tick();
        chk("rel_pp4", press_pulse, 4'h0);
        chk("rel_st4", stateful_button, 4'hF);

        button = 4'h0;
        run(6);
        chk("rel_st_hold", stateful_button, 4'hF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_st", stateful_button, 4'h0);

        // two-cycle glitch is rejected
        clr_cnt();
        button = 4'h1;
        run(2);
        button = 4'h0;
        run(4);
        chk_n("glitch_pp", pp_n[0], 0);
        chk("glitch_st", stateful_button, 4'h0);

        // two clean presses toggle 0->1->0
        clr_cnt();
        button = 4'h1;
        run(2);
        chk("tg1_early", press_pulse, 4'h0);
        tick();
        chk("tg1_pp", press_pulse, 4'h1);
        chk("tg1_st", stateful_button, 4'h1);
        run(3);
        button = 4'h0;
        run(6);
        chk("tg1_rel", stateful_button, 4'h1);
        button = 4'h1;
        run(3);
        chk("tg2_pp", press_pulse, 4'h1);
        chk("tg2_st", stateful_button, 4'h0);
        run(3);
        button = 4'h0;
        run(6);
        chk_n("tg_pp_count", pp_n[0], 2);
        chk_n("tg_lp_count", lp_n[0], 0);

        // 20-cycle hold: one long press 8 cycles after the press strobe
        clr_cnt();
        button = 4'h1;
        run(3);
        chk("lp_pp", press_pulse, 4'h1);
        run(7);
        chk("lp_early", long_press, 4'h0);
        tick();
        chk("lp_fire", long_press, 4'h1);
        tick();
        chk("lp_once", long_press, 4'h0);
        run(8);
        button = 4'h0;
        run(6);
        chk_n("lp_count", lp_n[0], 1);
        chk_n("lp_pp_count", pp_n[0], 1);

        // 5-cycle hold: no long press
        clr_cnt();
        button = 4'h1;
        run(5);
        button = 4'h0;
        run(6);
        chk_n("short_lp", lp_n[0], 0);
        chk("short_st", stateful_button, 4'h0);

        // mixed modes: ch0 toggle, ch1 momentary, ch2 latch, ch3 off
        clr_cnt();
        mode   = 8'b11_10_01_00;
        button = 4'hF;
        run(2);
        chk("md_st_pre", stateful_button, 4'h0);
        tick();
        chk("md_pp", press_pulse, 4'b0111);
        chk("md_st", stateful_button, 4'b0111);
        run(3);
        button = 4'h0;
        run(2);
        chk("md_rel_lag", stateful_button, 4'b0111);
        tick();
        chk("md_rel", stateful_button, 4'b0101);
        run(3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("md_clr", stateful_button, 4'h0);
        tick();
        chk("md_clr_hold", stateful_button, 4'h0);

        button = 4'hF;
        run(3);
        chk("md2_st", stateful_button, 4'b0111);
        run(8);
        chk("md2_lp", long_press, 4'b0111);
        run(2);
        button = 4'h0;
        run(6);
        chk("md2_rel", stateful_button, 4'b0101);
        chk_n("md_ch3_pp", pp_n[3], 0);
        chk_n("md_ch3_lp", lp_n[3], 0);
        chk_n("md_ch2_pp", pp_n[2], 2);

        // back to toggle: values retained; clear on the press edge
        mode = 8'h00;
        tick();
        chk("tg_ret", stateful_button, 4'b0101);
        button = 4'h1;
        run(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_press_st", stateful_button, 4'h0);
        chk("clr_press_pp", press_pulse, 4'h1);
        button = 4'h0;
        run(6);

        // reset mid-debounce discards the count
        clr_cnt();
        button = 4'h1;
        run(2);
        rst = 1'b1;
        tick();
        chk("rst_mid_pp", press_pulse, 4'h0);
        rst = 1'b0;
        run(2);
        chk("rst_mid_wait", press_pulse, 4'h0);
        tick();
        chk("rst_mid_pp3", press_pulse, 4'h1);
        chk("rst_mid_st", stateful_button, 4'h1);
        chk_n("rst_mid_count", pp_n[0], 1);
        button = 4'h0;
        run(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
